and2_arbiter: RTL and testbench
===============================

# and2_arbiter

Round-robin arbiter and sequencer that shares one registered AND unit (the `and2` datapath) among `NUM_REQ` requesters. It accepts operand pairs through per-requester valid/ready handshakes and drives the unit's operand inputs. It tracks each in-flight operation's requester ID through the unit's latency and returns each result tagged with its requester ID. A flush/quiesce FSM lets the system stop issue and drain the unit before reconfiguration or reset release of downstream logic.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `WIDTH`, default 2: operand/result width.
- `UNIT_LAT`, default 1: clock edges from `unit_a`/`unit_b` update to `unit_c` reflecting it, 1..4.
- `IDW`, default `max(1,clog2(NUM_REQ))`: width of the requester ID.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_a`, `req_b`  in  NUM_REQ*WIDTH  packed operands; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- `unit_a`, `unit_b`  out  WIDTH  registered operands to the shared AND unit.
- `unit_c`  in  WIDTH  result from the unit.
- `rsp_valid`  out  1  result valid this cycle.
- `rsp_id`  out  IDW  requester index of current result.
- `rsp_c`  out  WIDTH  result; equals `unit_c`; meaningful only when `rsp_valid` is high.
- `flush_req`  in  1  level request to stop issue and drain.
- `flush_done`  out  1  high while in HALT (unit empty, no issue).
- `issue_cnt`  out  16  total accepted requests; wraps from 0xFFFF to 0.

## Operation
- Handshake: a transfer occurs on an edge where `req_valid[i] && req_ready[i]`. Requester i holds `req_valid`, `req_a` and `req_b` stable until accepted. The arbiter never drops an accepted request.
- Grant: combinational round-robin search starting at pointer `ptr` (reset 0). The first i (mod NUM_REQ) with `req_valid[i]` is granted.
- `req_ready[i]` is high only when all of the following hold: i is the grant, state is RUN, and `flush_req` is low.
- On transfer, these updates occur on the same edge:
  - `ptr <= (i+1) mod NUM_REQ`.
  - `unit_a <= req_a[i]` and `unit_b <= req_b[i]`.
  - A tag {valid=1, id=i} enters the UNIT_LAT-deep tag shift register.
  - `issue_cnt` increments.
- With no transfer, `unit_a`/`unit_b` hold their values and a {valid=0} tag is shifted in.
- Response: `rsp_valid` and `rsp_id` are the tail of the tag pipeline; `rsp_c = unit_c`. No response backpressure; a result is presented for exactly one cycle.
- FSM states and transitions:
  - RUN: if `flush_req` is high, go to DRAIN.
  - DRAIN: no issue. When every tag stage is invalid, including the tail about to be presented, go to HALT. DRAIN always completes even if `flush_req` drops.
  - HALT: `flush_done` = 1. When `flush_req` is low, go to RUN.
- Simultaneous events:
  - `flush_req` rising in the same cycle as a pending grant: `req_ready` is already gated low, so no transfer occurs.
  - Entering DRAIN with an empty pipeline: reach HALT on the next edge.
- Reset (async, any time):
  - State returns to RUN and `ptr` to 0.
  - Tags, `unit_a`, `unit_b` and `issue_cnt` clear to 0.
  - In-flight results are discarded; no `rsp_valid` is emitted for them.

## Timing
- Reset values: `req_ready`=0 (until first cycle with valid), `unit_a`=0, `unit_b`=0, `rsp_valid`=0, `rsp_id`=0, `flush_done`=0, `issue_cnt`=0.
- Latency: a transfer at edge E0 gives `rsp_valid`=1 in the cycle following edge E0+UNIT_LAT.
- Throughput: one transfer per cycle sustained. Responses arrive in issue order, one per cycle, with no bubbles.
- Fairness: with all NUM_REQ requesters continuously valid, each is granted exactly once in every NUM_REQ consecutive cycles.
- Flush: `flush_done` rises at most UNIT_LAT+1 edges after `flush_req` is sampled high. After `flush_req` falls, RUN resumes and issue restarts 1 edge later.

## Test plan
1. Reset, then idle:
   - Outputs: all outputs 0.
   - `req_valid`=0 for 10 cycles: `rsp_valid` stays 0 and `issue_cnt`=0.
2. Single request, UNIT_LAT=1: requester 0 with a=2'b11, b=2'b01.
   - Acceptance: `req_ready[0]` high; `unit_a`=2'b11 after the edge.
   - Response: one cycle later, `rsp_valid`=1, `rsp_id`=0, `rsp_c`=2'b01; `issue_cnt`=1.
3. All four requesters valid for 8 cycles, each with a=2'b11, b=2'b1x:
   - Grant order: 0,1,2,3,0,1,2,3.
   - Responses: `rsp_id` sequence matches, with `rsp_valid` continuous; `issue_cnt`=8.
4. Pointer wrap: after a grant to 3, assert requesters 0 and 2 together.
   - Grant order: 0 is granted first, then 2.
5. Flush with 2 requests in flight, UNIT_LAT=2:
   - Issue stop: `req_ready` drops in the same cycle `flush_req` rises.
   - Drain: both responses are delivered, then `flush_done`=1.
   - Resume: drop `flush_req`; the next grant occurs 1 edge later.
6. Reset asserted mid-cycle with 2 tags in flight:
   - Asynchronous clear: outputs clear immediately, with no clock edge needed.
   - Discard: no `rsp_valid` follows; `issue_cnt`=0 and `ptr` restarts at 0.

Source files
------------

// File: rtl/and2_arbiter.sv
// Round-robin arbiter feeding one shared registered AND unit; tags each issue with its
// requester ID, returns tagged results in order, and can stop issue and drain on request.
module and2_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 2,
  parameter int UNIT_LAT = 1,
  parameter int IDW      = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]           unit_a,
  output logic [WIDTH-1:0]           unit_b,
  input  logic [WIDTH-1:0]           unit_c,
  output logic                       rsp_valid,
  output logic [IDW-1:0]             rsp_id,
  output logic [WIDTH-1:0]           rsp_c,
  input  logic                       flush_req,
  output logic                       flush_done,
  output logic [15:0]                issue_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t               state;
  logic [IDW-1:0]       ptr;
  logic [NUM_REQ-1:0]   at_or_after;
  logic [NUM_REQ-1:0]   upper;
  logic [NUM_REQ-1:0]   sel;
  logic [NUM_REQ-1:0]   onehot;
  logic [IDW-1:0][NUM_REQ-1:0]   id_t;
  logic [WIDTH-1:0][NUM_REQ-1:0] a_t;
  logic [WIDTH-1:0][NUM_REQ-1:0] b_t;
  logic [IDW-1:0]       grant_id;
  logic [WIDTH-1:0]     grant_a;
  logic [WIDTH-1:0]     grant_b;
  logic                 issue_en;
  logic                 transfer;
  logic [IDW-1:0]       in_id;

  // Tag stage 0 sits alongside unit_a/unit_b; the remaining UNIT_LAT stages track
  // the unit latency so the tail lines up with unit_c.
  logic [UNIT_LAT:0]           tag_valid;
  logic [UNIT_LAT:0][IDW-1:0]  tag_id;

  // Requesters at or after ptr take priority; otherwise wrap to the lowest index.
  assign upper = req_valid & at_or_after;
  assign sel   = (|upper) ? upper : req_valid;

  genvar gi, gb;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      localparam logic [NUM_REQ-1:0] LOWER = NUM_REQ'((1 << gi) - 1);
      assign at_or_after[gi] = (IDW'(gi) >= ptr);
      assign onehot[gi]      = sel[gi] & ~(|(sel & LOWER));
      for (gb = 0; gb < IDW; gb++) begin : g_idbit
        assign id_t[gb][gi] = (((gi >> gb) & 1) == 1);
      end
      for (gb = 0; gb < WIDTH; gb++) begin : g_opbit
        assign a_t[gb][gi] = req_a[gi*WIDTH + gb];
        assign b_t[gb][gi] = req_b[gi*WIDTH + gb];
      end
    end
    for (gb = 0; gb < IDW; gb++) begin : g_gid
      assign grant_id[gb] = |(onehot & id_t[gb]);
    end
    for (gb = 0; gb < WIDTH; gb++) begin : g_gop
      assign grant_a[gb] = |(onehot & a_t[gb]);
      assign grant_b[gb] = |(onehot & b_t[gb]);
    end
  endgenerate

  assign issue_en  = (state == RUN) && !flush_req;
  assign req_ready = issue_en ? onehot : '0;
  assign transfer  = |req_ready;
  assign in_id     = transfer ? grant_id : '0;

  assign rsp_valid = tag_valid[UNIT_LAT];
  assign rsp_id    = tag_id[UNIT_LAT];
  assign rsp_c     = unit_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      unit_a    <= '0;
      unit_b    <= '0;
      issue_cnt <= '0;
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid <= {tag_valid[UNIT_LAT-1:0], transfer};
      tag_id    <= {tag_id[UNIT_LAT-1:0], in_id};
      if (transfer) begin
        ptr       <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        unit_a    <= grant_a;
        unit_b    <= grant_b;
        issue_cnt <= issue_cnt + 16'd1;
      end
    end
  end

  // DRAIN ignores flush_req so a started drain always reaches HALT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      flush_done <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (flush_req) state <= DRAIN;
        end
        DRAIN: begin
          if (!(|tag_valid)) begin
            state      <= HALT;
            flush_done <= 1'b1;
          end
        end
        HALT: begin
          if (!flush_req) begin
            state      <= RUN;
            flush_done <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          flush_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_and2_arbiter.sv
// Bench for and2_arbiter: one instance with UNIT_LAT=1 and one with UNIT_LAT=2,
// each fed by a behavioural registered AND unit of matching latency.
module tb_and2_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_valid;
  logic [7:0] req_a, req_b;
  logic       flush_req;

  logic [3:0]  ready1, ready2;
  logic [1:0]  ua1, ub1, uc1, ua2, ub2, uc2, s2;
  logic        rv1, rv2, fd1, fd2;
  logic [1:0]  rid1, rid2, rc1, rc2;
  logic [15:0] cnt1, cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  and2_arbiter #(.NUM_REQ(4), .WIDTH(2), .UNIT_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(ready1), .unit_a(ua1), .unit_b(ub1), .unit_c(uc1),
    .rsp_valid(rv1), .rsp_id(rid1), .rsp_c(rc1),
    .flush_req(flush_req), .flush_done(fd1), .issue_cnt(cnt1)
  );

  and2_arbiter #(.NUM_REQ(4), .WIDTH(2), .UNIT_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(ready2), .unit_a(ua2), .unit_b(ub2), .unit_c(uc2),
    .rsp_valid(rv2), .rsp_id(rid2), .rsp_c(rc2),
    .flush_req(flush_req), .flush_done(fd2), .issue_cnt(cnt2)
  );

  // Shared AND unit models: one and two register stages.
  always @(posedge clk) begin
    uc1 <= ua1 & ub1;
    s2  <= ua2 & ub2;
    uc2 <= s2;
  end

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  rdy;
    logic        rv;
    logic [1:0]  rid;
    logic [1:0]  rc;
    logic [15:0] cnt;
    logic        chk_ua;
    logic [1:0]  ua;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    req_valid = 4'h0;
    flush_req = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_a = 8'h00;
    req_b = 8'h00;

    // Reset state and idle
    do_reset();
    #1;
    check("rst.req_ready", 32'(ready1), 32'h0);
    check("rst.unit_a",    32'(ua1), 32'h0);
    check("rst.unit_b",    32'(ub1), 32'h0);
    check("rst.rsp_valid", 32'(rv1), 32'h0);
    check("rst.rsp_id",    32'(rid1), 32'h0);
    check("rst.flush_done", 32'(fd1), 32'h0);
    check("rst.issue_cnt", 32'(cnt1), 32'h0);
    check("rst.issue_cnt2", 32'(cnt2), 32'h0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #2;
      check($sformatf("idle%0d.rsp_valid", k), 32'(rv1), 32'h0);
    end
    check("idle.issue_cnt", 32'(cnt1), 32'h0);
    $display("idle: 10 cycles, issue_cnt=%0d", cnt1);

    // Single request
    vecs.push_back('{1'b1, 4'h1, 8'h03, 8'h01, 4'h1, 1'b0, 2'd0, 2'd0, 16'd0, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'h0, 8'h03, 8'h01, 4'h0, 1'b0, 2'd0, 2'd0, 16'd1, 1'b1, 2'b11});
    vecs.push_back('{1'b0, 4'h0, 8'h00, 8'h00, 4'h0, 1'b1, 2'd0, 2'b01, 16'd1, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'h0, 8'h00, 8'h00, 4'h0, 1'b0, 2'd0, 2'd0, 16'd1, 1'b0, 2'd0});
    // All four valid for 8 cycles: b per requester = 10,11,10,11
    vecs.push_back('{1'b1, 4'hF, 8'hFF, 8'hEE, 4'h1, 1'b0, 2'd0, 2'd0,  16'd0, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'hF, 8'hFF, 8'hEE, 4'h2, 1'b0, 2'd0, 2'd0,  16'd1, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'hF, 8'hFF, 8'hEE, 4'h4, 1'b1, 2'd0, 2'b10, 16'd2, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'hF, 8'hFF, 8'hEE, 4'h8, 1'b1, 2'd1, 2'b11, 16'd3, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'hF, 8'hFF, 8'hEE, 4'h1, 1'b1, 2'd2, 2'b10, 16'd4, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'hF, 8'hFF, 8'hEE, 4'h2, 1'b1, 2'd3, 2'b11, 16'd5, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'hF, 8'hFF, 8'hEE, 4'h4, 1'b1, 2'd0, 2'b10, 16'd6, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'hF, 8'hFF, 8'hEE, 4'h8, 1'b1, 2'd1, 2'b11, 16'd7, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'h0, 8'hFF, 8'hEE, 4'h0, 1'b1, 2'd2, 2'b10, 16'd8, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'h0, 8'hFF, 8'hEE, 4'h0, 1'b1, 2'd3, 2'b11, 16'd8, 1'b0, 2'd0});
    // Pointer wrap after grant to 3: 0 and 2 together, then 3 ahead of 0
    vecs.push_back('{1'b0, 4'h5, 8'hFF, 8'hEE, 4'h1, 1'b0, 2'd0, 2'd0,  16'd8,  1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'h4, 8'hFF, 8'hEE, 4'h4, 1'b0, 2'd0, 2'd0,  16'd9,  1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'h9, 8'hFF, 8'hEE, 4'h8, 1'b1, 2'd0, 2'b10, 16'd10, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'h1, 8'hFF, 8'hEE, 4'h1, 1'b1, 2'd2, 2'b10, 16'd11, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'h0, 8'hFF, 8'hEE, 4'h0, 1'b1, 2'd3, 2'b11, 16'd12, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'h0, 8'hFF, 8'hEE, 4'h0, 1'b1, 2'd0, 2'b10, 16'd12, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'h0, 8'hFF, 8'hEE, 4'h0, 1'b0, 2'd0, 2'd0,  16'd12, 1'b0, 2'd0});

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      req_valid = vecs[i].v;
      req_a     = vecs[i].a;
      req_b     = vecs[i].b;
      flush_req = 1'b0;
      #1;
      check($sformatf("v%0d.req_ready", i), 32'(ready1), 32'(vecs[i].rdy));
      check($sformatf("v%0d.rsp_valid", i), 32'(rv1), 32'(vecs[i].rv));
      check($sformatf("v%0d.issue_cnt", i), 32'(cnt1), 32'(vecs[i].cnt));
      if (vecs[i].rv) begin
        check($sformatf("v%0d.rsp_id", i), 32'(rid1), 32'(vecs[i].rid));
        check($sformatf("v%0d.rsp_c", i),  32'(rc1),  32'(vecs[i].rc));
      end
      if (vecs[i].chk_ua) check($sformatf("v%0d.unit_a", i), 32'(ua1), 32'(vecs[i].ua));
      $display("vec %0d: valid=%b ready=%b rsp_valid=%b rsp_id=%0d rsp_c=%b issue_cnt=%0d",
               i, req_valid, ready1, rv1, rid1, rc1, cnt1);
      @(posedge clk);
      #2;
    end

    // Flush with two requests in flight on the UNIT_LAT=2 instance
    begin
      int nrsp;
      int waited;
      do_reset();
      req_a = 8'hFF;
      req_b = 8'hEE;
      req_valid = 4'b0011;
      #1;
      check("flush.grant0", 32'(ready2), 32'h1);
      @(posedge clk);
      #2;
      req_valid = 4'b0010;
      #1;
      check("flush.grant1", 32'(ready2), 32'h2);
      @(posedge clk);
      #2;
      req_valid = 4'b0001;
      flush_req = 1'b1;
      #1;
      check("flush.ready_gated", 32'(ready2), 32'h0);
      check("flush.done_early", 32'(fd2), 32'h0);
      $display("flush: raised with 2 in flight, ready=%b", ready2);
      @(posedge clk);
      #2;
      nrsp   = 0;
      waited = 0;
      for (int k = 0; k < 8 && !fd2; k++) begin
        #1;
        check($sformatf("drain%0d.req_ready", k), 32'(ready2), 32'h0);
        if (rv2) begin
          if (nrsp < 2) begin
            check($sformatf("drain.rsp%0d.id", nrsp), 32'(rid2), 32'(nrsp));
            check($sformatf("drain.rsp%0d.c", nrsp), 32'(rc2),
                  (nrsp == 0) ? 32'h2 : 32'h3);
          end
          $display("drain: rsp id=%0d c=%b", rid2, rc2);
          nrsp++;
        end
        @(posedge clk);
        #2;
        waited++;
      end
      check("drain.flush_done", 32'(fd2), 32'h1);
      check("drain.rsp_count", 32'(nrsp), 32'h2);
      check("drain.edges_le_3", 32'(waited <= 3), 32'h1);
      @(posedge clk);
      #2;
      check("halt.hold_done", 32'(fd2), 32'h1);
      check("halt.hold_ready", 32'(ready2), 32'h0);
      flush_req = 1'b0;
      #1;
      check("resume.same_cycle_ready", 32'(ready2), 32'h0);
      @(posedge clk);
      #2;
      check("resume.ready", 32'(ready2), 32'h1);
      check("resume.done_low", 32'(fd2), 32'h0);
      check("resume.cnt_before", 32'(cnt2), 32'h2);
      @(posedge clk);
      #2;
      check("resume.cnt_after", 32'(cnt2), 32'h3);
      $display("resume: issue_cnt=%0d", cnt2);
      req_valid = 4'h0;
    end

    // Asynchronous reset with two tags in flight on the UNIT_LAT=1 instance
    do_reset();
    req_a = 8'hFF;
    req_b = 8'hEE;
    req_valid = 4'b0001;
    @(posedge clk);
    #2;
    req_valid = 4'b0010;
    @(posedge clk);
    #2;
    req_valid = 4'b0000;
    #1;
    check("areset.pre_rsp_valid", 32'(rv1), 32'h1);
    check("areset.pre_cnt", 32'(cnt1), 32'h2);
    reset = 1'b1;
    #1;
    check("areset.rsp_valid", 32'(rv1), 32'h0);
    check("areset.issue_cnt", 32'(cnt1), 32'h0);
    check("areset.unit_a", 32'(ua1), 32'h0);
    check("areset.unit_b", 32'(ub1), 32'h0);
    check("areset.flush_done", 32'(fd1), 32'h0);
    $display("areset: mid-cycle clear, rsp_valid=%b issue_cnt=%0d", rv1, cnt1);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #2;
      check($sformatf("areset.after%0d.rsp_valid", k), 32'(rv1), 32'h0);
    end
    req_valid = 4'hF;
    #1;
    check("areset.ptr_restart", 32'(ready1), 32'h1);
    req_valid = 4'h0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
